mult_seq: RTL
=============

# mult_seq

Parametrised iterative shift-add multiplier with selectable signed/unsigned mode and a start/done handshake. Retires one multiplier bit per clock, using a single WIDTH-bit adder in place of a fully unrolled array. Used by the ALU/execute stage where area matters more than single-cycle latency. Produces the full 2*WIDTH-bit product as HI/LO, in the same format as the combinational multipliers.

## Interface
Parameters:
- WIDTH, 32, operand width in bits. Must be at least 4. HI and LO are each WIDTH bits.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  reset; asynchronous, active-low.
- START  input  1  request pulse; sampled only while BUSY=0.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; captured with START.
- A  input  WIDTH  multiplicand; captured with START.
- B  input  WIDTH  multiplier; captured with START.
- HI  output  WIDTH  upper half of the product; registered.
- LO  output  WIDTH  lower half of the product; registered.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; HI/LO are valid and updated in the same cycle.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - On START=1, capture SIGNED, A and B.
  - If SIGNED=1 and the operand's MSB=1, replace that operand with its two's-complement magnitude.
  - Record neg = SIGNED & (A[MSB] ^ B[MSB]).
  - Clear the WIDTH-bit accumulator and the carry.
  - Load the iteration counter with 0 and go to CALC.
- CALC, one iteration per cycle:
  - If the multiplier's LSB is 1, add the magnitude multiplicand to the accumulator, producing a (WIDTH+1)-bit sum.
  - Shift {carry, accumulator, multiplier} right by 1; the accumulator LSB shifts into the multiplier MSB.
  - Increment the counter. After iteration WIDTH-1, go to FIX.
- FIX:
  - The 2*WIDTH-bit product is {accumulator, multiplier}.
  - If neg=1, take its 2*WIDTH-bit two's complement.
  - Write the result to HI/LO, pulse DONE and return to IDLE.
- Arithmetic:
  - The magnitude of the most negative value, 2^(WIDTH-1), is represented as an unsigned WIDTH-bit quantity without error.
  - The product of two most-negative values is +2^(2*WIDTH-2).
  - No overflow is possible.
  - A or B equal to 0 gives a 0 product with neg ignored; -0 is never produced.
- HI/LO hold their value from DONE until the next DONE. They never change during CALC.
- START while BUSY=1 is ignored; there is no queueing.
- Changes on A, B or SIGNED after the capture cycle have no effect.

## Timing
- Reset values: HI=0, LO=0, BUSY=0, DONE=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. HI/LO clear to 0 and no DONE is issued.
- Accept edge t, where START=1 and state is IDLE:
  - BUSY=1 from t to t+WIDTH+1.
  - CALC occupies edges t+1 .. t+WIDTH.
  - FIX is on edge t+WIDTH+1: HI/LO are updated, DONE=1 and BUSY=0 for the following cycle.
- Latency from the START edge to DONE is WIDTH+1 cycles. Throughput is one operation per WIDTH+1 cycles.
- DONE is high for exactly one cycle per accepted START.
- START may be asserted in the DONE cycle, because the state is already IDLE. It is accepted there, giving back-to-back operations with no gap.
- BUSY and DONE are never high in the same cycle.

## Test plan
- WIDTH=32, SIGNED=0, A=0x7FFFFFFF, B=0x70000000 -> after 33 cycles DONE=1, HI=0x37FFFFFF, LO=0x90000000.
- WIDTH=32, SIGNED=1, A=0x80000001, B=0x70000000 -> HI=0xC8000000, LO=0x70000000. Then SIGNED=1 with A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- WIDTH=32, A=B=0xFFFFFFFF:
  - SIGNED=0 -> HI=0xFFFFFFFE, LO=0x00000001.
  - SIGNED=1 -> HI=0x00000000, LO=0x00000001.
  - Both issued back-to-back, with the second START in the first DONE cycle -> two DONE pulses exactly 33 cycles apart.
- WIDTH=8, SIGNED=1, A=0x80, B=0x7F -> DONE after 9 cycles, HI=0xC0, LO=0x80.
- WIDTH=8, SIGNED=1, A=0x00, B=0x85 -> HI=0x00, LO=0x00.
- Protocol check (WIDTH=32):
  - Extra START pulses at cycles 5 and 20 of a busy operation are ignored. A and B are changed mid-operation with no effect on the result.
  - RST pulsed low at cycle 10 of a second operation -> HI=LO=0, BUSY=0, no DONE pulse.
  - A subsequent START completes normally.

Source files
------------

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier, one multiplier bit retired per clock.
//
// Signed operands are converted to magnitudes on capture, multiplied unsigned,
// and the sign is re-applied to the full 2*WIDTH-bit product at the end. The
// magnitude of the most negative value (2^(WIDTH-1)) fits exactly in an
// unsigned WIDTH-bit register, so no operand widening is needed.
//
// Ports
//   CLK     rising-edge clock
//   RST     asynchronous active-low reset
//   START   request pulse, sampled only while BUSY=0
//   SIGNED  1 = two's-complement operands, 0 = unsigned (captured with START)
//   A, B    multiplicand / multiplier (captured with START)
//   HI, LO  registered upper / lower product halves, updated with DONE
//   BUSY    high from the accept edge until the result is written
//   DONE    one-cycle pulse when HI/LO take a new result
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;    // multiplicand magnitude
  logic [WIDTH-1:0] mplier;   // multiplier; low product bits shift in from the top
  logic [WIDTH-1:0] acc;      // running upper half of the product
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-1:0] aMag, bMag, addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod, prodFix;

  // Operand magnitudes for the capture cycle.
  always_comb begin
    aMag = A;
    bMag = B;
    if (SIGNED && A[WIDTH-1]) aMag = ~A + WIDTH'(1);
    if (SIGNED && B[WIDTH-1]) bMag = ~B + WIDTH'(1);
  end

  // The single adder. Its carry-out becomes the accumulator MSB after the
  // shift, so no separate carry register has to survive between cycles.
  always_comb begin
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
  end

  // Sign fix-up of the finished product. A zero product negates to zero,
  // so -0 cannot appear.
  always_comb begin
    prod    = {acc, mplier};
    prodFix = neg ? (~prod + PW'(1)) : prod;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            mcand <= aMag;
            mplier <= bMag;
            neg   <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // {carry, acc, mplier} >> 1 after the conditional add.
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          HI    <= prodFix[PW-1:WIDTH];
          LO    <= prodFix[WIDTH-1:0];
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
